alu_op_sequencer: RTL and testbench

//  Control-side driver for ArithmeticLogicUnit. Accepts an operation request over valid/ready
//  and drives A, B, FunSel and WF for 1..16 back-to-back iterations, feeding ALUOut back as A.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_iter_ctr.sv | 39 +++
 rtl/alu_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants, state encoding and helpers for the ALU
// operation sequencer and anything that talks to it.
package alu_seq_pkg;

   localparam int DATA_W = 16;

   localparam logic [3:0] FS_NOT_A = 4'b0010;
   localparam logic [3:0] FS_ADD   = 4'b0100;
   localparam logic [3:0] FS_ADDC  = 4'b0101;
   localparam logic [3:0] FS_SUB   = 4'b0110;
   localparam logic [3:0] FS_LSL   = 4'b1011;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      CAPT,
      RESP
   } seqState_t;

   // In 8-bit mode only the low byte of a value is meaningful; clear the rest.
   function automatic logic [DATA_W-1:0] maskWidth(input logic [DATA_W-1:0] value,
                                                   input logic             wide);
      return wide ? value : {8'h00, value[7:0]};
   endfunction

endpackage

// File: rtl/alu_seq_iter_ctr.sv
// alu_seq_iter_ctr: iteration bookkeeping for the sequencer. A down-counter
// tracks how many extra iterations remain, an up-counter reports how many
// iterations have actually been executed.
module alu_seq_iter_ctr #(
   parameter int MAX_ITER_W = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [MAX_ITER_W-1:0] loadValue,
   input  logic                  decrement,
   output logic                  last,
   output logic [MAX_ITER_W:0]   iterCnt
);

   localparam logic [MAX_ITER_W-1:0] CNT_ONE  = 1;
   localparam logic [MAX_ITER_W:0]   ITER_ONE = 1;

   logic [MAX_ITER_W-1:0] cnt;

   // Load both counters at request accept; each executed iteration bumps iterCnt and consumes one remaining count.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt     <= '0;
         iterCnt <= '0;
      end else if (load) begin
         cnt     <= loadValue;
         iterCnt <= '0;
      end else if (decrement) begin
         iterCnt <= iterCnt + ITER_ONE;
         if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the ArithmeticLogicUnit for 1..16 back-to-back
// iterations of one operation, feeding ALUOut back into A, then returns the
// final result, the ALU flags and the iteration count over valid/ready.
// Optional feature: define ALU_SEQ_EARLY_EXIT_EN to end the run as soon as
// an iteration produces a zero result.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int MAX_ITER_W = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic [3:0]            ReqOp,
   input  logic                  ReqWide,
   input  logic                  ReqSetFlags,
   input  logic [MAX_ITER_W-1:0] ReqRepeat,
   input  logic [15:0]           ReqA,
   input  logic [15:0]           ReqB,
   output logic [15:0]           AluA,
   output logic [15:0]           AluB,
   output logic [4:0]            FunSel,
   output logic                  WF,
   input  logic [15:0]           ALUOut,
   input  logic [3:0]            FlagsOut,
   output logic                  RspValid,
   input  logic                  RspReady,
   output logic [15:0]           RspData,
   output logic [3:0]            RspFlags,
   output logic [MAX_ITER_W:0]   RspCount
);

   seqState_t state;
   seqState_t nextState;

   logic [15:0]         acc;
   logic [15:0]         opB;
   logic [3:0]          opCode;
   logic                opWide;
   logic                opSetFlags;
   logic                ctrLoad;
   logic                ctrStep;
   logic                ctrLast;
   logic                lastIter;
   logic [MAX_ITER_W:0] iterCnt;

   alu_seq_iter_ctr #(
      .MAX_ITER_W(MAX_ITER_W)
   ) iterCtr (
      .clock    (Clock),
      .reset    (Reset),
      .load     (ctrLoad),
      .loadValue(ReqRepeat),
      .decrement(ctrStep),
      .last     (ctrLast),
      .iterCnt  (iterCnt)
   );

   // State register; a reset anywhere abandons the current request without a response.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and ALU-facing outputs; the ALU is only driven while iterating so it idles on FunSel=0.
   always_comb begin
      nextState = state;
      ReqReady  = 1'b0;
      RspValid  = 1'b0;
      AluA      = '0;
      AluB      = '0;
      FunSel    = '0;
      WF        = 1'b0;
      ctrLoad   = 1'b0;
      ctrStep   = 1'b0;
      lastIter  = 1'b0;
      case (state)
         IDLE: begin
            ReqReady = 1'b1;
            if (ReqValid) begin
               ctrLoad   = 1'b1;
               nextState = EXEC;
            end
         end
         EXEC: begin
            AluA     = acc;
            AluB     = opB;
            FunSel   = {opWide, opCode};
            WF       = opSetFlags;
            ctrStep  = 1'b1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
            lastIter = ctrLast || (maskWidth(ALUOut, opWide) == 16'h0000);
`else
            lastIter = ctrLast;
`endif
            if (lastIter) begin
               nextState = CAPT;
            end
         end
         CAPT: begin
            nextState = RESP;
         end
         RESP: begin
            RspValid = 1'b1;
            if (RspReady) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Operand latching, accumulator feedback and response capture. Flags are taken in CAPT because the
   // ALU flag register only reflects the last iteration one edge after its WF.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         acc        <= '0;
         opB        <= '0;
         opCode     <= '0;
         opWide     <= 1'b0;
         opSetFlags <= 1'b0;
         RspData    <= '0;
         RspFlags   <= '0;
         RspCount   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  acc        <= maskWidth(ReqA, ReqWide);
                  opB        <= ReqB;
                  opCode     <= ReqOp;
                  opWide     <= ReqWide;
                  opSetFlags <= ReqSetFlags;
               end
            end
            EXEC: begin
               acc <= maskWidth(ALUOut, opWide);
            end
            CAPT: begin
               RspData  <= acc;
               RspFlags <= FlagsOut;
               RspCount <= iterCnt;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: exercises the sequencer against a behavioural ALU with
// a flag register, using directed scenarios plus randomized requests checked
// against an iteration-level reference model.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [3:0]  ReqOp;
   logic        ReqWide;
   logic        ReqSetFlags;
   logic [3:0]  ReqRepeat;
   logic [15:0] ReqA;
   logic [15:0] ReqB;
   logic [15:0] AluA;
   logic [15:0] AluB;
   logic [4:0]  FunSel;
   logic        WF;
   logic [15:0] ALUOut;
   logic [3:0]  FlagsOut;
   logic        RspValid;
   logic        RspReady;
   logic [15:0] RspData;
   logic [3:0]  RspFlags;
   logic [4:0]  RspCount;

   int          checks = 0;
   int          passes = 0;
   logic [3:0]  modelFlags;
   logic [15:0] obsData;
   logic [3:0]  obsFlags;
   logic [4:0]  obsCount;
   int          obsLatency;
   logic        obsSawWf;

   alu_op_sequencer #(
      .MAX_ITER_W(4)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqOp      (ReqOp),
      .ReqWide    (ReqWide),
      .ReqSetFlags(ReqSetFlags),
      .ReqRepeat  (ReqRepeat),
      .ReqA       (ReqA),
      .ReqB       (ReqB),
      .AluA       (AluA),
      .AluB       (AluB),
      .FunSel     (FunSel),
      .WF         (WF),
      .ALUOut     (ALUOut),
      .FlagsOut   (FlagsOut),
      .RspValid   (RspValid),
      .RspReady   (RspReady),
      .RspData    (RspData),
      .RspFlags   (RspFlags),
      .RspCount   (RspCount)
   );

   always #5 Clock = ~Clock;

   // Behavioural ALU: returns {Z,C,N,O,result}; NOT keeps C/O, LSL keeps O.
   function automatic logic [19:0] aluCalc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [4:0] fs, input logic [3:0] flagsIn);
      logic        wide;
      logic [15:0] am;
      logic [15:0] bm;
      logic [15:0] res;
      logic [16:0] full;
      logic        carryOut;
      logic        sa;
      logic        sb;
      logic        sr;
      logic        c;
      logic        o;
      wide = fs[4];
      am   = wide ? a : {8'h00, a[7:0]};
      bm   = wide ? b : {8'h00, b[7:0]};
      c    = flagsIn[FLAG_C];
      o    = flagsIn[FLAG_O];
      full = {1'b0, am};
      case (fs[3:0])
         FS_NOT_A: full = {1'b0, ~am};
         FS_ADD:   full = {1'b0, am} + {1'b0, bm};
         FS_ADDC:  full = {1'b0, am} + {1'b0, bm} + {16'h0000, flagsIn[FLAG_C]};
         FS_SUB:   full = {1'b0, am} + {1'b0, (wide ? ~bm : {8'h00, ~bm[7:0]})} + 17'd1;
         FS_LSL:   full = {am, 1'b0};
         default:  full = {1'b0, am};
      endcase
      res      = wide ? full[15:0] : {8'h00, full[7:0]};
      carryOut = wide ? full[16] : full[8];
      sa       = wide ? am[15] : am[7];
      sb       = wide ? bm[15] : bm[7];
      sr       = wide ? res[15] : res[7];
      case (fs[3:0])
         FS_ADD, FS_ADDC: begin
            c = carryOut;
            o = (sa == sb) && (sr != sa);
         end
         FS_SUB: begin
            c = carryOut;
            o = (sa != sb) && (sr != sa);
         end
         FS_LSL: c = carryOut;
         default: ;
      endcase
      return {(res == 16'h0000), c, sr, o, res};
   endfunction

   logic [3:0]  aluFlagReg;
   logic [19:0] aluResult;

   assign aluResult = aluCalc(AluA, AluB, FunSel, aluFlagReg);
   assign ALUOut    = aluResult[15:0];
   assign FlagsOut  = aluFlagReg;

   // ALU flag register, written on the shared clock whenever WF is high.
   always @(posedge Clock) begin
      if (Reset) aluFlagReg <= 4'b0000;
      else if (WF) aluFlagReg <= aluResult[19:16];
   end

   // Iteration-level reference: repeat the operation on the running value and track the flag register.
   task automatic refModel(input logic [3:0] op, input logic wide, input logic setFlags,
                           input logic [3:0] rep, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] data, output logic [3:0] flags, output int count);
      logic [15:0] acc;
      logic [3:0]  f;
      logic [19:0] r;
      bit          done;
      acc   = wide ? a : {8'h00, a[7:0]};
      f     = modelFlags;
      count = 0;
      done  = 0;
      for (int i = 0; i <= int'(rep) && !done; i++) begin
         r   = aluCalc(acc, b, {wide, op}, f);
         acc = r[15:0];
         if (setFlags) f = r[19:16];
         count++;
`ifdef ALU_SEQ_EARLY_EXIT_EN
         if (acc == 16'h0000) done = 1;
`endif
      end
      modelFlags = f;
      data       = acc;
      flags      = f;
   endtask

   // Issue one request (entered at a negedge) and wait for the response, recording what was seen.
   task automatic applyStimulus(input logic [3:0] op, input logic wide, input logic setFlags,
                                input logic [3:0] rep, input logic [15:0] a, input logic [15:0] b);
      int waitCycles;
      obsSawWf   = 1'b0;
      obsLatency = -1;
      waitCycles = 0;
      while (!ReqReady && waitCycles < 50) begin
         @(negedge Clock);
         waitCycles++;
      end
      if (!ReqReady) begin
         checks++;
         $display("[TB] FAIL req_ready_wait got ReqReady=%b expected 1 within 50 cycles", ReqReady);
         return;
      end
      ReqValid    = 1'b1;
      ReqOp       = op;
      ReqWide     = wide;
      ReqSetFlags = setFlags;
      ReqRepeat   = rep;
      ReqA        = a;
      ReqB        = b;
      @(posedge Clock);
      @(negedge Clock);
      ReqValid   = 1'b0;
      waitCycles = 0;
      while (!RspValid && waitCycles < 100) begin
         if (WF) obsSawWf = 1'b1;
         @(negedge Clock);
         waitCycles++;
      end
      if (!RspValid) begin
         checks++;
         $display("[TB] FAIL rsp_wait got RspValid=%b expected 1 within 100 cycles", RspValid);
         return;
      end
      obsLatency = waitCycles;
      obsData    = RspData;
      obsFlags   = RspFlags;
      obsCount   = RspCount;
   endtask

   // Complete the response handshake and return at a negedge.
   task automatic finishRsp();
      RspReady = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      RspReady = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      checks++;
      if (ReqReady !== 1'b1) $display("[TB] FAIL reset_reqready got %b expected 1", ReqReady);
      else passes++;
      checks++;
      if ({RspValid, WF, FunSel} !== 7'b0) $display("[TB] FAIL reset_ctrl got %b expected 0000000", {RspValid, WF, FunSel});
      else passes++;
      checks++;
      if ({AluA, AluB} !== 32'h0) $display("[TB] FAIL reset_alu_ops got %h expected 00000000", {AluA, AluB});
      else passes++;
      checks++;
      if ({RspData, RspFlags, RspCount} !== 25'h0) $display("[TB] FAIL reset_rsp got %h expected 0", {RspData, RspFlags, RspCount});
      else passes++;
      Reset      = 1'b0;
      modelFlags = 4'b0000;
      @(negedge Clock);
   endtask

   task automatic test_add_wide();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_ADD, 1'b1, 1'b1, 4'd0, 16'h1234, 16'h4321, eData, eFlags, eCount);
      applyStimulus(FS_ADD, 1'b1, 1'b1, 4'd0, 16'h1234, 16'h4321);
      checks++;
      if (obsData !== 16'h5555) $display("[TB] FAIL add_data got %h expected 5555", obsData);
      else passes++;
      checks++;
      if (obsFlags !== 4'b0000) $display("[TB] FAIL add_flags got %b expected 0000", obsFlags);
      else passes++;
      checks++;
      if (obsCount !== 5'd1) $display("[TB] FAIL add_count got %0d expected 1", obsCount);
      else passes++;
      checks++;
      if (obsLatency != 2) $display("[TB] FAIL add_latency got %0d expected 2", obsLatency);
      else passes++;
      checks++;
      if (obsSawWf !== 1'b1) $display("[TB] FAIL add_wf got %b expected 1", obsSawWf);
      else passes++;
      finishRsp();
   endtask

   task automatic test_lsl_narrow();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_LSL, 1'b0, 1'b0, 4'd3, 16'h00A5, 16'h0000, eData, eFlags, eCount);
      applyStimulus(FS_LSL, 1'b0, 1'b0, 4'd3, 16'h00A5, 16'h0000);
      checks++;
      if (obsData !== 16'h0050) $display("[TB] FAIL lsl_data got %h expected 0050", obsData);
      else passes++;
      checks++;
      if (obsFlags !== 4'b0000) $display("[TB] FAIL lsl_flags got %b expected 0000", obsFlags);
      else passes++;
      checks++;
      if (obsCount !== 5'd4) $display("[TB] FAIL lsl_count got %0d expected 4", obsCount);
      else passes++;
      checks++;
      if (obsLatency != 5) $display("[TB] FAIL lsl_latency got %0d expected 5", obsLatency);
      else passes++;
      finishRsp();
   endtask

   task automatic test_sub_flags();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_SUB, 1'b1, 1'b1, 4'd0, 16'h4E20, 16'h9E58, eData, eFlags, eCount);
      applyStimulus(FS_SUB, 1'b1, 1'b1, 4'd0, 16'h4E20, 16'h9E58);
      checks++;
      if (obsData !== 16'hAFC8) $display("[TB] FAIL sub_data got %h expected afc8", obsData);
      else passes++;
      checks++;
      if (obsFlags !== 4'b0011) $display("[TB] FAIL sub_flags got %b expected 0011", obsFlags);
      else passes++;
      finishRsp();
   endtask

   task automatic test_no_flags();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_ADD, 1'b1, 1'b0, 4'd0, 16'h0001, 16'h0001, eData, eFlags, eCount);
      applyStimulus(FS_ADD, 1'b1, 1'b0, 4'd0, 16'h0001, 16'h0001);
      checks++;
      if (obsSawWf !== 1'b0) $display("[TB] FAIL noflags_wf got %b expected 0", obsSawWf);
      else passes++;
      checks++;
      if (obsData !== 16'h0002) $display("[TB] FAIL noflags_data got %h expected 0002", obsData);
      else passes++;
      checks++;
      if (obsFlags !== 4'b0011) $display("[TB] FAIL noflags_flags got %b expected 0011", obsFlags);
      else passes++;
      finishRsp();
   endtask

   task automatic test_hold_and_reset();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_ADD, 1'b1, 1'b1, 4'd2, 16'h0100, 16'h0011, eData, eFlags, eCount);
      applyStimulus(FS_ADD, 1'b1, 1'b1, 4'd2, 16'h0100, 16'h0011);
      checks++;
      if (obsData !== 16'h0133) $display("[TB] FAIL hold_data got %h expected 0133", obsData);
      else passes++;
      ReqValid  = 1'b1;
      ReqRepeat = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         checks++;
         if ({RspValid, ReqReady, RspData, RspFlags, RspCount} !== {1'b1, 1'b0, eData, eFlags, 5'(eCount)})
            $display("[TB] FAIL hold_stable cycle %0d got %h expected %h", i,
                     {RspValid, ReqReady, RspData, RspFlags, RspCount}, {1'b1, 1'b0, eData, eFlags, 5'(eCount)});
         else passes++;
      end
      ReqValid = 1'b0;
      finishRsp();
      ReqValid    = 1'b1;
      ReqOp       = FS_ADD;
      ReqWide     = 1'b1;
      ReqSetFlags = 1'b1;
      ReqRepeat   = 4'd7;
      ReqA        = 16'h0001;
      ReqB        = 16'h0001;
      @(posedge Clock);
      @(negedge Clock);
      ReqValid = 1'b0;
      @(negedge Clock);
      checks++;
      if (WF !== 1'b1) $display("[TB] FAIL exec_wf got %b expected 1", WF);
      else passes++;
      Reset = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      checks++;
      if ({RspValid, WF, ReqReady} !== 3'b001) $display("[TB] FAIL midreset got %b expected 001", {RspValid, WF, ReqReady});
      else passes++;
      Reset      = 1'b0;
      modelFlags = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (RspValid !== 1'b0) begin
            checks++;
            $display("[TB] FAIL dropped_rsp cycle %0d got RspValid=%b expected 0", i, RspValid);
            break;
         end
      end
      checks++;
      if (ReqReady !== 1'b1) $display("[TB] FAIL post_reset_ready got %b expected 1", ReqReady);
      else passes++;
   endtask

   task automatic test_saturating_shift();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_LSL, 1'b0, 1'b1, 4'd7, 16'h0080, 16'h0000, eData, eFlags, eCount);
      applyStimulus(FS_LSL, 1'b0, 1'b1, 4'd7, 16'h0080, 16'h0000);
      checks++;
      if (obsData !== 16'h0000) $display("[TB] FAIL sat_data got %h expected 0000", obsData);
      else passes++;
`ifdef ALU_SEQ_EARLY_EXIT_EN
      checks++;
      if (obsCount !== 5'd1) $display("[TB] FAIL sat_count got %0d expected 1", obsCount);
      else passes++;
      checks++;
      if (obsFlags !== 4'b1100) $display("[TB] FAIL sat_flags got %b expected 1100", obsFlags);
      else passes++;
`else
      checks++;
      if (obsCount !== 5'd8) $display("[TB] FAIL sat_count got %0d expected 8", obsCount);
      else passes++;
      checks++;
      if (obsFlags !== 4'b1000) $display("[TB] FAIL sat_flags got %b expected 1000", obsFlags);
      else passes++;
`endif
      checks++;
      if (obsLatency != eCount + 1) $display("[TB] FAIL sat_latency got %0d expected %0d", obsLatency, eCount + 1);
      else passes++;
      finishRsp();
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic        wide;
      logic        setFlags;
      logic [3:0]  rep;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 4))
            0:       op = FS_NOT_A;
            1:       op = FS_ADD;
            2:       op = FS_ADDC;
            3:       op = FS_SUB;
            default: op = FS_LSL;
         endcase
         wide     = 1'($urandom_range(0, 1));
         setFlags = 1'($urandom_range(0, 1));
         rep      = 4'($urandom_range(0, 15));
         a        = 16'($urandom);
         b        = 16'($urandom);
         refModel(op, wide, setFlags, rep, a, b, eData, eFlags, eCount);
         applyStimulus(op, wide, setFlags, rep, a, b);
         checks++;
         if (obsData !== eData) $display("[TB] FAIL rand%0d_data got %h expected %h", n, obsData, eData);
         else passes++;
         checks++;
         if (obsFlags !== eFlags) $display("[TB] FAIL rand%0d_flags got %b expected %b", n, obsFlags, eFlags);
         else passes++;
         checks++;
         if (obsCount !== 5'(eCount)) $display("[TB] FAIL rand%0d_count got %0d expected %0d", n, obsCount, eCount);
         else passes++;
         checks++;
         if (obsLatency != eCount + 1) $display("[TB] FAIL rand%0d_latency got %0d expected %0d", n, obsLatency, eCount + 1);
         else passes++;
         checks++;
         if (obsSawWf !== setFlags) $display("[TB] FAIL rand%0d_wf got %b expected %b", n, obsSawWf, setFlags);
         else passes++;
         finishRsp();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] eData;
      logic [3:0]  eFlags;
      int          eCount;
      refModel(FS_ADDC, 1'b0, 1'b1, 4'd2, 16'h00F0, 16'h0090, eData, eFlags, eCount);
      applyStimulus(FS_ADDC, 1'b0, 1'b1, 4'd2, 16'h00F0, 16'h0090);
      checks++;
      if ({obsData, obsFlags} !== {eData, eFlags}) $display("[TB] FAIL b2b_first got %h expected %h", {obsData, obsFlags}, {eData, eFlags});
      else passes++;
      ReqValid = 1'b1;
      finishRsp();
      checks++;
      if ({ReqReady, RspValid} !== 2'b10) $display("[TB] FAIL b2b_idle_gap got %b expected 10", {ReqReady, RspValid});
      else passes++;
      refModel(FS_ADDC, 1'b0, 1'b1, 4'd1, 16'h0001, 16'h00FF, eData, eFlags, eCount);
      applyStimulus(FS_ADDC, 1'b0, 1'b1, 4'd1, 16'h0001, 16'h00FF);
      checks++;
      if ({obsData, obsFlags, obsCount} !== {eData, eFlags, 5'(eCount)})
         $display("[TB] FAIL b2b_second got %h expected %h", {obsData, obsFlags, obsCount}, {eData, eFlags, 5'(eCount)});
      else passes++;
      checks++;
      if (obsLatency != eCount + 1) $display("[TB] FAIL b2b_latency got %0d expected %0d", obsLatency, eCount + 1);
      else passes++;
      finishRsp();
   endtask

   initial begin
      Reset       = 1'b0;
      ReqValid    = 1'b0;
      ReqOp       = 4'h0;
      ReqWide     = 1'b0;
      ReqSetFlags = 1'b0;
      ReqRepeat   = 4'h0;
      ReqA        = 16'h0000;
      ReqB        = 16'h0000;
      RspReady    = 1'b0;
      modelFlags  = 4'b0000;
      @(negedge Clock);
      test_reset();
      test_add_wide();
      test_lsl_narrow();
      test_sub_flags();
      test_no_flags();
      test_hold_and_reset();
      test_saturating_shift();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
